// File: rtl/cfg_bank_writer.sv
// Memory-bank configuration writer: streams bitline rows in over valid/ready and strobes one wordline per row.
// Optional per-row even-parity beat enabled by defining CFG_BANK_PARITY_EN.
module cfg_bank_writer #(
  parameter int NUM_BL   = 72,
  parameter int NUM_WL   = 72,
  parameter int DATA_W   = 8,
  parameter int WL_PULSE = 2
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic [0:NUM_BL-1] bl,
  output logic [0:NUM_WL-1] wl,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        state_dbg
);

  // Handshake: a beat transfers on a rising prog_clk edge where cfg_valid & cfg_ready;
  // cfg_ready is a registered function of state only and never looks at cfg_valid.

  localparam int BEATS = NUM_BL / DATA_W;
`ifdef CFG_BANK_PARITY_EN
  localparam int LAST_BEAT = BEATS;
`else
  localparam int LAST_BEAT = BEATS - 1;
`endif
  localparam int BW = $clog2(BEATS + 2);
  localparam int RW = $clog2(NUM_WL + 1);
  localparam int PW = $clog2(WL_PULSE + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state;
  logic [BW-1:0] beat_cnt;
  logic [RW-1:0] row_cnt;
  logic [PW-1:0] pulse_cnt;
  logic          last_beat;
  logic          par_ok;

  assign state_dbg = state;
  assign last_beat = (beat_cnt == BW'(LAST_BEAT));

`ifdef CFG_BANK_PARITY_EN
  logic row_par;
  // All data beats are already in bl when the parity beat arrives.
  assign row_par = ^bl;
  assign par_ok  = !last_beat || (row_par == cfg_data[0]);
`else
  assign par_ok  = 1'b1;
`endif

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      row_cnt   <= '0;
      pulse_cnt <= '0;
      bl        <= '0;
      wl        <= '0;
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_LOAD;
            bl        <= '0;
            row_cnt   <= '0;
            beat_cnt  <= '0;
            err       <= 1'b0;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end

        S_LOAD: begin
          if (cfg_valid) begin
            for (int k = 0; k < BEATS; k++) begin
              if (beat_cnt == BW'(k)) begin
                for (int j = 0; j < DATA_W; j++) begin
                  bl[k*DATA_W + j] <= cfg_data[j];
                end
              end
            end
            if (last_beat) begin
              beat_cnt  <= '0;
              cfg_ready <= 1'b0;
              if (par_ok) begin
                state     <= S_PULSE;
                pulse_cnt <= '0;
                for (int i = 0; i < NUM_WL; i++) begin
                  wl[i] <= (row_cnt == RW'(i));
                end
              end else begin
                // Bad row: never strobe it, abandon the pass.
                state <= S_DONE;
                err   <= 1'b1;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end

        S_PULSE: begin
          if (pulse_cnt == PW'(WL_PULSE - 1)) begin
            wl    <= '0;
            state <= S_HOLD;
          end else begin
            pulse_cnt <= pulse_cnt + PW'(1);
          end
        end

        S_HOLD: begin
          row_cnt <= row_cnt + RW'(1);
          if (row_cnt == RW'(NUM_WL - 1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= S_LOAD;
            cfg_ready <= 1'b1;
          end
        end

        default: begin
          state     <= S_IDLE;
          wl        <= '0;
          cfg_ready <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_bank_writer.sv
// Directed bench for cfg_bank_writer (two-row bank); expected rows queued on send, checked at each wordline pulse.
module tb_cfg_bank_writer;

  localparam int NUM_BL   = 72;
  localparam int NUM_WL   = 2;
  localparam int DATA_W   = 8;
  localparam int WL_PULSE = 2;
  localparam int BEATS    = NUM_BL / DATA_W;
  localparam int W        = NUM_BL + 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [0:NUM_BL-1] bl;
  logic [0:NUM_WL-1] wl;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        state_dbg;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  cfg_bank_writer #(
    .NUM_BL(NUM_BL), .NUM_WL(NUM_WL), .DATA_W(DATA_W), .WL_PULSE(WL_PULSE)
  ) dut (
    .prog_clk(clk), .prog_rst_n(rst_n), .start(start), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .bl(bl), .wl(wl),
    .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  // clock / reset / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_BL-1:0] bl_vec();
    logic [NUM_BL-1:0] v;
    for (int i = 0; i < NUM_BL; i++) v[i] = bl[i];
    return v;
  endfunction

  function automatic int wl_idx();
    for (int i = 0; i < NUM_WL; i++) if (wl[i]) return i;
    return -1;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d);
    int n;
    n = 0;
    cfg_data  = d;
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cfg_ready) begin
      chk("beat_accept_timeout", 96'(cfg_ready), 96'(1));
      cfg_valid = 1'b0;
    end else begin
      tick();
    end
  endtask

  task automatic send_row(input logic [NUM_BL-1:0] bits, input int idx,
                          input bit toggle, input bit push, input bit bad_par);
    if (push) exp_q.push_back({8'(idx), bits});
    for (int k = 0; k < BEATS; k++) begin
      send_beat(bits[k*DATA_W +: DATA_W]);
      if (toggle) begin
        cfg_valid = 1'b0;
        tick();
      end
    end
`ifdef CFG_BANK_PARITY_EN
    send_beat({7'b0, (^bits) ^ bad_par});
`else
    if (bad_par) cfg_data = '0;
`endif
    cfg_valid = 1'b0;
  endtask

  function automatic logic [NUM_BL-1:0] rand_row();
    logic [NUM_BL-1:0] r;
    for (int k = 0; k < BEATS; k++) r[k*DATA_W +: DATA_W] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  // scoreboard monitor: pop one expected row per wordline pulse
  logic [0:NUM_WL-1] prev_wl;
  logic [NUM_BL-1:0] bl_cap;
  int plen;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst_n) begin
      prev_wl = '0;
      plen    = 0;
    end else begin
      if (wl != '0) begin
        if (prev_wl == '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 96'(wl_idx()), 96'hFFFF);
          end else begin
            e = exp_q.pop_front();
            chk("wl_row", 96'(wl_idx()), 96'(e[NUM_BL +: 8]));
            chk("bl_row", 96'(bl_vec()), 96'(e[NUM_BL-1:0]));
          end
          bl_cap = bl_vec();
          plen   = 1;
        end else begin
          plen++;
          chk("bl_stable_pulse", 96'(bl_vec()), 96'(bl_cap));
        end
        chk("wl_onehot", 96'($countones(wl)), 96'(1));
        chk("ready_low_pulse", 96'(cfg_ready), 96'(0));
      end else if (prev_wl != '0) begin
        chk("pulse_len", 96'(plen), 96'(WL_PULSE));
        chk("bl_stable_hold", 96'(bl_vec()), 96'(bl_cap));
        chk("ready_low_hold", 96'(cfg_ready), 96'(0));
      end
      prev_wl = wl;
    end
  end

  initial begin
    logic [NUM_BL-1:0] row, v;
    rst_n = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;

    // reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_bl", 96'(bl_vec()), 96'(0));
    chk("rst_wl", 96'(wl), 96'(0));
    chk("rst_ready", 96'(cfg_ready), 96'(0));
    chk("rst_flags", 96'({busy, done, err}), 96'(0));
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("idle_state", 96'(state_dbg), 96'(ST_IDLE));
    cfg_valid = 1'b1;  // ignored outside LOAD
    tick();
    cfg_valid = 1'b0;
    chk("idle_no_ready", 96'(cfg_ready), 96'(0));

    // pass A: beats 0x01..0x09 then 0x11..0x19, exact pulse timing
    pulse_start();
    chk("start_load", 96'({state_dbg, cfg_ready, busy}), 96'({ST_LOAD, 2'b11}));
    for (int k = 0; k < BEATS; k++) row[k*DATA_W +: DATA_W] = 8'(k + 1);
    send_row(row, 0, 1'b0, 1'b1, 1'b0);
    v = bl_vec();
    chk("bl_slice0", 96'(v[7:0]), 96'(8'h01));
    chk("bl_bit0", 96'(bl[0]), 96'(1));
    chk("bl_slice8", 96'(v[71:64]), 96'(8'h09));
    chk("wl0_t1", 96'(wl), 96'(2'b10));
    tick();
    chk("wl0_t2", 96'(wl), 96'(2'b10));
    tick();
    chk("hold_t3", 96'({state_dbg, wl}), 96'({ST_HOLD, 2'b00}));
    tick();
    chk("reload_t4", 96'({state_dbg, cfg_ready}), 96'({ST_LOAD, 1'b1}));
    for (int k = 0; k < BEATS; k++) row[k*DATA_W +: DATA_W] = 8'(8'h11 + k);
    send_row(row, 1, 1'b0, 1'b1, 1'b0);
    chk("wl1_t1", 96'(wl), 96'(2'b01));
    tick(); tick();
    chk("not_done_t3", 96'(done), 96'(0));
    tick();
    chk("done_t4", 96'({state_dbg, done, busy, cfg_ready}), 96'({ST_DONE, 3'b100}));

    // pass B: restart from DONE, start ignored mid-LOAD, toggling valid on row 1
    pulse_start();
    chk("restart_clear", 96'({bl_vec(), done, cfg_ready}), 96'({72'b0, 2'b01}));
    row = rand_row();
    exp_q.push_back({8'd0, row});
    for (int k = 0; k < 3; k++) send_beat(row[k*DATA_W +: DATA_W]);
    cfg_valid = 1'b0;
    pulse_start();
    chk("start_ignored", 96'({state_dbg, busy}), 96'({ST_LOAD, 1'b1}));
    for (int k = 3; k < BEATS; k++) send_beat(row[k*DATA_W +: DATA_W]);
`ifdef CFG_BANK_PARITY_EN
    send_beat({7'b0, ^row});
`endif
    cfg_valid = 1'b0;
    send_row(rand_row(), 1, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    chk("passb_done", 96'({state_dbg, done}), 96'({ST_DONE, 1'b1}));

    // pass C: reset while wl[0] is high
    pulse_start();
    row = rand_row();
    send_row(row, 0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_wl", 96'(wl), 96'(2'b10));
    chk("pre_rst_bl", 96'(bl_vec()), 96'(row));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outs", 96'({wl, cfg_ready, busy, done, err}), 96'(0));
    chk("midrst_bl", 96'(bl_vec()), 96'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_idle", 96'({state_dbg, done, cfg_ready}), 96'({ST_IDLE, 2'b00}));

    // pass D: all-ones rows, good then bad parity beat
    pulse_start();
    send_row({NUM_BL{1'b1}}, 0, 1'b0, 1'b1, 1'b0);
`ifdef CFG_BANK_PARITY_EN
    send_row({NUM_BL{1'b1}}, 1, 1'b0, 1'b0, 1'b1);
    chk("par_fail_state", 96'({state_dbg, done, err, busy}), 96'({ST_DONE, 3'b110}));
    chk("par_fail_nowl", 96'(wl), 96'(0));
    repeat (3) tick();
    chk("par_err_sticky", 96'({err, wl}), 96'({1'b1, 2'b00}));
`else
    row = {NUM_BL{1'b1}};
    row[7:0] = 8'h00;
    send_row(row, 1, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    chk("nopar_done", 96'({state_dbg, done, err}), 96'({ST_DONE, 2'b10}));
`endif
    pulse_start();
    chk("err_cleared", 96'({err, done}), 96'(0));

    chk("queue_empty", 96'(exp_q.size()), 96'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
